// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg: register map, STATUS layout and serializer state encoding shared with the address decoder
package uart_tx_mmio_pkg;
  localparam logic [3:0] OFF_TXD     = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_BAUDDIV = 4'h8;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 4;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  // word-granular match: the two low address bits never take part in decoding
  function automatic logic reg_hit(input logic [31:0] addr, input logic [31:0] base, input logic [3:0] off);
    logic [31:0] a;
    a = base + {28'b0, off};
    return addr[31:2] == a[31:2];
  endfunction
endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: CPU MEM-stage data bus as seen by a memory-mapped peripheral
interface uart_tx_mmio_if;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        MemWrite;
  logic        MemRead;
  modport master (output Address, output Write_data, output MemWrite, output MemRead, input Read_data);
  modport slave (input Address, input Write_data, input MemWrite, input MemRead, output Read_data);
endinterface

// File: rtl/uart_tx_mmio_tx_fifo.sv
// tx_fifo: DEPTH x 8 synchronous transmit queue; a push into a full queue lands only when a pop frees a slot that same edge
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rd_ptr];
  // storage needs no reset: pointers and count alone define what is valid
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with byte FIFO, programmable baud divider and idle interrupt
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
  parameter int          DEPTH     = 4,
  parameter logic [15:0] DIV_RST   = 16'd868
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           irq
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, state_n;
  logic [15:0] div, bit_div, bit_div_n, cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n, head, status;
  logic [CW-1:0] count;
  logic tx_n, ovf, pop, full, empty, busy, tick;
  logic hit_txd, hit_status, hit_baud, txd_wr, baud_wr, status_rd;
  assign hit_txd = reg_hit(bus.Address, BASE_ADDR, OFF_TXD);
  assign hit_status = reg_hit(bus.Address, BASE_ADDR, OFF_STATUS);
  assign hit_baud = reg_hit(bus.Address, BASE_ADDR, OFF_BAUDDIV);
  assign txd_wr = bus.MemWrite && hit_txd;
  assign baud_wr = bus.MemWrite && hit_baud;
  assign status_rd = bus.MemRead && hit_status;
  assign busy = state != IDLE;
  assign irq = empty && !busy;
  assign tick = cnt == '0;
  tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (txd_wr),
    .pop   (pop),
    .wdata (bus.Write_data[7:0]),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // STATUS image; only the low four count bits fit the register field
  always_comb begin
    status = '0;
    status[ST_CNT +: 4] = 4'(count);
    status[ST_OVF] = ovf;
    status[ST_BUSY] = busy;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
  end
  assign bus.Read_data = !bus.MemRead ? '0 : hit_status ? {24'b0, status} : hit_baud ? {16'b0, div} : '0;
  // divider register and sticky overflow; a set in the same cycle as a STATUS read wins
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      div <= DIV_RST;
      ovf <= 1'b0;
    end else begin
      if (baud_wr) div <= (bus.Write_data[15:0] == '0) ? 16'd1 : bus.Write_data[15:0];
      ovf <= (txd_wr && full && !pop) || (ovf && !status_rd);
    end
  // frame sequencing: the divider is sampled at START so a mid-frame BAUDDIV write waits for the next frame
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bit_div_n = bit_div;
    idx_n = idx;
    shreg_n = shreg;
    tx_n = tx;
    pop = 1'b0;
    if (busy && !tick) cnt_n = cnt - 16'd1;
    else if ((state == IDLE || state == STOP) && !empty) begin
      pop = 1'b1;
      state_n = START;
      shreg_n = head;
      bit_div_n = div;
      cnt_n = div - 16'd1;
      tx_n = 1'b0;
    end else if (busy) begin
      cnt_n = bit_div - 16'd1;
      case (state)
        START: begin
          state_n = DATA;
          idx_n = '0;
          tx_n = shreg[0];
        end
        DATA: begin
          state_n = idx == 3'd7 ? STOP : DATA;
          idx_n = idx + 3'd1;
          tx_n = idx == 3'd7 ? 1'b1 : shreg[idx + 3'd1];
        end
        default: begin
          state_n = IDLE;
          tx_n = 1'b1;
        end
      endcase
    end
  end
  // serializer registers; reset drops any frame in flight and forces the line idle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_div <= DIV_RST;
      idx <= '0;
      shreg <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_div <= bit_div_n;
      idx <= idx_n;
      shreg <= shreg_n;
      tx <= tx_n;
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: register vectors, directed frame sequences and randomized bursts against a line-level model
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'h4000_0018;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx, irq;
  uart_tx_mmio_if bus();
  uart_tx_mmio #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DIV_RST(16'd868)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .irq   (irq)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic log_en = 1'b0;
  logic txlog[$];
  logic irqlog[$];
  logic [7:0] bytes_v [8];
  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tv [14];
  // per-cycle line and interrupt capture, index 0 = state after the first TXD store edge
  always @(posedge clk) begin
    #1;
    if (log_en) begin
      txlog.push_back(tx);
      irqlog.push_back(irq);
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.Address = a;
    bus.Write_data = d;
    bus.MemWrite = 1'b1;
    @(negedge clk);
    bus.MemWrite = 1'b0;
  endtask
  task automatic load(input logic [31:0] a, output logic [31:0] d);
    bus.Address = a;
    bus.MemRead = 1'b1;
    #1 d = bus.Read_data;
    @(negedge clk);
    bus.MemRead = 1'b0;
  endtask
  // store n bytes back to back and compare the whole line against concatenated 8N1 frames
  task automatic burst(input string tag, input logic [15:0] dw, input int n, input bit mid, input logic [15:0] mdw);
    int d0, d1, acc, len, pos, bad, g, d;
    logic [31:0] r;
    logic e[$];
    d0 = dw == 0 ? 1 : int'(dw);
    d1 = mid ? (mdw == 0 ? 1 : int'(mdw)) : d0;
    store(BASE + 32'd8, {16'h0, dw});
    txlog.delete();
    irqlog.delete();
    log_en = 1'b1;
    for (int i = 0; i < n; i++) store(BASE, {24'h0, bytes_v[i]});
    if (mid) store(BASE + 32'd8, {16'h0, mdw});
    acc = n < DEPTH + 1 ? n : DEPTH + 1;
    e.push_back(1'b1);
    for (int f = 0; f < acc; f++)
      for (int k = 0; k < 10; k++)
        for (int j = 0; j < (f == 0 ? d0 : d1); j++)
          e.push_back(k == 0 ? 1'b0 : k == 9 ? 1'b1 : bytes_v[f][k-1]);
    len = e.size();
    for (int i = 0; i < 4; i++) e.push_back(1'b1);
    g = 0;
    while (txlog.size() < e.size() && g < 5000) begin
      @(negedge clk);
      g++;
    end
    log_en = 1'b0;
    check($sformatf("%s capture complete", tag), txlog.size() >= e.size(), 1);
    pos = 1;
    for (int f = 0; f < acc; f++) begin
      d = f == 0 ? d0 : d1;
      bad = 0;
      for (int i = pos; i < pos + 10 * d; i++) if (i >= txlog.size() || txlog[i] !== e[i]) bad++;
      check($sformatf("%s frame%0d bad samples", tag, f), bad, 0);
      pos += 10 * d;
    end
    bad = 0;
    for (int i = 0; i < e.size(); i++) if ((i == 0 || i >= len) && (i >= txlog.size() || txlog[i] !== 1'b1)) bad++;
    check($sformatf("%s idle line bad samples", tag), bad, 0);
    bad = 0;
    for (int i = 0; i < e.size(); i++) if (i >= irqlog.size() || irqlog[i] !== (i >= len)) bad++;
    check($sformatf("%s irq bad samples", tag), bad, 0);
    load(BASE + 32'd4, r);
    check($sformatf("%s status after", tag), r, n > DEPTH + 1 ? 32'h0A : 32'h02);
    load(BASE + 32'd4, r);
    check($sformatf("%s status reread", tag), r, 32'h02);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [31:0] r;
    bus.Address = '0;
    bus.Write_data = '0;
    bus.MemWrite = 1'b0;
    bus.MemRead = 1'b0;
    tv[0]  = '{1'b0, 1'b1, BASE + 32'd4,  32'h0,         32'h2};
    tv[1]  = '{1'b0, 1'b1, BASE + 32'd8,  32'h0,         32'd868};
    tv[2]  = '{1'b0, 1'b1, BASE,          32'h0,         32'h0};
    tv[3]  = '{1'b0, 1'b1, BASE + 32'd12, 32'h0,         32'h0};
    tv[4]  = '{1'b0, 1'b0, BASE + 32'd4,  32'h0,         32'h0};
    tv[5]  = '{1'b1, 1'b0, BASE + 32'd12, 32'hFFFF_FFFF, 32'h0};
    tv[6]  = '{1'b1, 1'b0, BASE - 32'd4,  32'h0000_00A5, 32'h0};
    tv[7]  = '{1'b0, 1'b1, BASE + 32'd4,  32'h0,         32'h2};
    tv[8]  = '{1'b0, 1'b1, BASE + 32'd8,  32'h0,         32'd868};
    tv[9]  = '{1'b1, 1'b0, BASE + 32'd10, 32'h0,         32'h0};
    tv[10] = '{1'b0, 1'b1, BASE + 32'd9,  32'h0,         32'h1};
    tv[11] = '{1'b1, 1'b0, BASE + 32'd8,  32'hABCD_0007, 32'h0};
    tv[12] = '{1'b0, 1'b1, BASE + 32'd11, 32'h0,         32'h7};
    tv[13] = '{1'b0, 1'b1, BASE + 32'd4,  32'h0,         32'h2};
    #1 reset = 1'b0;
    #1 check("reset tx", tx, 1);
    check("reset irq", irq, 1);
    bus.Address = BASE + 32'd4;
    bus.MemRead = 1'b1;
    #1 check("reset status", bus.Read_data, 32'h2);
    bus.MemRead = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      if (tv[i].wr) store(tv[i].addr, tv[i].wdata);
      else if (tv[i].rd) begin
        load(tv[i].addr, r);
        check($sformatf("vec%0d read 0x%0h", i, tv[i].addr), r, tv[i].exp);
      end else begin
        bus.Address = tv[i].addr;
        #1 check($sformatf("vec%0d no-read 0x%0h", i, tv[i].addr), bus.Read_data, tv[i].exp);
        @(negedge clk);
      end
    end
    check("no frame after unmapped stores", tx, 1);
    check("irq idle after vectors", irq, 1);
    bytes_v[0] = 8'hA5;
    burst("a5_div4", 16'd4, 1, 1'b0, 16'd0);
    for (int i = 0; i < 5; i++) bytes_v[i] = 8'(i + 1);
    burst("five_div2", 16'd2, 5, 1'b0, 16'd0);
    bytes_v[0] = 8'h3C;
    burst("div0", 16'd0, 1, 1'b0, 16'd0);
    load(BASE + 32'd8, r);
    check("div0 readback", r, 32'h1);
    bytes_v[0] = 8'h5A;
    bytes_v[1] = 8'hC3;
    burst("div4to8", 16'd4, 2, 1'b1, 16'd8);
    store(BASE + 32'd8, 32'd100);
    txlog.delete();
    irqlog.delete();
    log_en = 1'b1;
    for (int i = 0; i < 6; i++) store(BASE, 32'h11 + i);
    load(BASE + 32'd4, r);
    check("full status", r, 32'h4D);
    load(BASE + 32'd4, r);
    check("full status ovf cleared", r, 32'h45);
    while (txlog.size() < 450) @(negedge clk);
    log_en = 1'b0;
    check("tx in data bit3", tx, 0);
    #2 reset = 1'b0;
    #1 check("tx async reset", tx, 1);
    check("irq async reset", irq, 1);
    @(negedge clk);
    load(BASE + 32'd4, r);
    check("status during reset", r, 32'h2);
    reset = 1'b1;
    load(BASE + 32'd4, r);
    check("status after release", r, 32'h2);
    load(BASE + 32'd8, r);
    check("bauddiv after release", r, 32'd868);
    check("tx idle after release", tx, 1);
    for (int it = 0; it < 6; it++) begin
      int n;
      logic [15:0] dw, mdw;
      bit mid;
      n = $urandom_range(1, 6);
      dw = 16'($urandom_range(0, 5));
      mid = 1'($urandom_range(0, 1));
      mdw = 16'($urandom_range(0, 6));
      for (int i = 0; i < 8; i++) bytes_v[i] = 8'($urandom);
      burst($sformatf("rand%0d", it), dw, n, mid, mdw);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter BASE_ADDR, default 32'h4000_0018, byte address of the TXD register; STATUS at BASE_ADDR+4, BAUDDIV at BASE_ADDR+8.
REQ-002 Parameter DEPTH, default 4, transmit FIFO depth in bytes, power of two, 2..16.
REQ-003 Parameter DIV_RST, default 16'd868, BAUDDIV reset value (100 MHz / 115200).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low; clears all state while low.
REQ-006 Address  input  32  CPU data-bus byte address, MEM stage.
REQ-007 Write_data  input  32  CPU store data.
REQ-008 MemWrite  input  1  store strobe, one cycle per store.
REQ-009 MemRead  input  1  load strobe.
REQ-010 Read_data  output  32  load data, combinational.
REQ-011 tx  output  1  serial line, idle high, 8N1, LSB first.
REQ-012 irq  output  1  high while the FIFO is empty and the FSM is IDLE.

Function
REQ-013 Responder only: register writes need MemWrite=1 and Address match on bits [31:2]; Address[1:0] ignored; other addresses are ignored and do not stall.
REQ-014 Store to TXD: if FIFO not full, Write_data[7:0] is enqueued at that edge; if full, the byte is dropped and sticky OVF is set.
REQ-015 Store to BAUDDIV: Write_data[15:0] is latched; 0 is stored as 1; the new value applies from the next START, never mid-frame.
REQ-016 Load (MemRead=1) of STATUS returns {24'b0, count[3:0], OVF, busy, empty, full} in bits [7:0]; BAUDDIV returns {16'b0, div}; TXD and unmapped addresses return 0; with MemRead=0, Read_data=0.
REQ-017 A STATUS load clears OVF at the same edge; OVF set and clear in the same cycle leaves OVF=1.
REQ-018 FSM states IDLE, START, DATA, STOP; busy=1 in any state other than IDLE.
REQ-019 IDLE with FIFO non-empty pops the head at the next edge and enters START; tx=0 from that edge.
REQ-020 Each bit holds for exactly div clk cycles via a 16-bit down-counter reloaded at every bit boundary.
REQ-021 DATA sends bits 0..7 tracked by a 3-bit index; after bit 7, enter STOP with tx=1.
REQ-022 At the end of STOP: FIFO non-empty -> START directly (no idle gap); otherwise -> IDLE.
REQ-023 Frame length is exactly 10*div cycles; first-byte latency from the store edge to tx falling is 1 cycle.
REQ-024 Push and pop in the same cycle are both honored when the FIFO is full: count is unchanged and the byte is accepted.
REQ-025 FIFO pointers wrap modulo DEPTH; count ranges 0..DEPTH; full = (count==DEPTH).
REQ-026 tx is driven from a register, glitch-free.

Reset
REQ-027 While reset=0: tx=1, state=IDLE, FIFO empty, pointers 0, OVF=0, div=DIV_RST, bit counter 0, irq=1, Read_data follows REQ-016.
REQ-028 Reset asserted mid-frame aborts the frame immediately with tx=1; partial bytes are lost.
REQ-029 Reset release is asynchronous; the first active edge after release behaves as IDLE with an empty FIFO.

Structure
REQ-030 The register offsets (0x0 TXD, 0x4 STATUS, 0x8 BAUDDIV), STATUS bit positions and FSM state encodings live in a shared package used by the data-memory address decoder.
REQ-031 One sub-module, tx_fifo (synchronous DEPTH x 8, push/pop/full/empty/count), is instantiated once; the FSM and baud counter stay in uart_tx_mmio.

Verification
REQ-032 Reset, BAUDDIV=4, store 0xA5 to TXD -> tx falls 1 cycle later; line reads 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit; irq returns to 1 after 40 cycles.
REQ-033 BAUDDIV=2, five back-to-back stores 0x01..0x05 with DEPTH=4 -> first four bytes transmitted contiguously (80 cycles, no idle gap); fifth byte is accepted only if the first pop occurred; STATUS OVF matches the expectation.
REQ-034 Store while full with the FSM idle-stalled (div large), 6 stores -> STATUS shows full=1, count=4, OVF=1; a second STATUS read shows OVF=0.
REQ-035 Write BAUDDIV=0 -> read-back is 1; frame lasts 10 cycles; BAUDDIV write mid-frame (4->8) leaves the current frame at 40 cycles and the next frame at 80.
REQ-036 Assert reset during DATA bit 3 -> tx=1 within the same cycle, STATUS=0x02, BAUDDIV=868 after release.
REQ-037 Load from an unmapped address (BASE_ADDR+12) and a store there -> Read_data=0, no state change.
